conv_frame_ctrl: RTL and testbench

//  Frame sequencer for the rate-1/2, K=5 convolutional encoder (g0=5'b11101, g1=5'b10011, 3-edge latency).

---
 rtl/conv_frame_ctrl_if.sv | 27 ++
 rtl/conv_frame_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_conv_frame_ctrl.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/conv_frame_ctrl_if.sv
// Stream-in / encoder / coded-stream-out signal bundle for conv_frame_ctrl.
interface conv_frame_ctrl_if;
    logic       s_valid;
    logic       s_ready;
    logic       s_data;
    logic       s_last;
    logic       enc_data_in;
    logic [1:0] enc_code_in;
    logic       m_valid;
    logic [1:0] m_code;
    logic       m_sof;
    logic       m_eof;
    logic       err_underrun;
    logic       busy;

    // Frame controller side
    modport master (
        input  s_valid, s_data, s_last, enc_code_in,
        output s_ready, enc_data_in, m_valid, m_code, m_sof, m_eof, err_underrun, busy
    );

    // Environment side: bit source, encoder and coded-stream sink
    modport slave (
        output s_valid, s_data, s_last, enc_code_in,
        input  s_ready, enc_data_in, m_valid, m_code, m_sof, m_eof, err_underrun, busy
    );
endinterface

// File: rtl/conv_frame_ctrl.sv
// Frame sequencer for the rate-1/2 K=5 convolutional encoder.
// Buffers input bits, feeds the encoder gap-free per frame, appends TAIL_LEN
// zero bits and tags the coded stream with valid/sof/eof/underrun flags.
// All flops update on the falling clock edge. TAIL_LEN must be >= 2.
module conv_frame_ctrl #(
    parameter int unsigned DEPTH    = 64,
    parameter int unsigned TAIL_LEN = 4,
    parameter int unsigned ENC_LAT  = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    conv_frame_ctrl_if.master bus
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned TW = $clog2(TAIL_LEN + 1);
    localparam logic [TW-1:0] TCNT_LAST = TW'(TAIL_LEN - 1);

    typedef enum logic [1:0] {IDLE, DATA, TAIL} state_t;

    typedef struct packed {
        logic vld;
        logic sof;
        logic eof;
        logic err;
    } tag_t;

    logic [1:0]    mem [DEPTH];
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]   fr_cnt_q, fr_cnt_d;
    logic          drop_q, drop_d;
    state_t        state_q, state_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          sof_pend_q, sof_pend_d;
    logic          enc_q, enc_d;
    tag_t          tag_q, tag_d;
    tag_t          pipe_q [ENC_LAT];

    logic       empty, full, accept, push, pop, underrun, drop_eff, start_ok;
    logic       head_bit, head_last, busy_c;
    logic [1:0] head;

    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head      = mem[rd_ptr_q[AW-1:0]];
    assign head_last = head[1];
    assign head_bit  = head[0];
    assign accept    = bus.s_valid & ~full;
    assign start_ok  = (fr_cnt_q != '0) | full;

    // Sequencer: choose the next bit for the encoder and its tag
    always_comb begin
        state_d    = state_q;
        tcnt_d     = tcnt_q;
        sof_pend_d = sof_pend_q;
        enc_d      = 1'b0;
        tag_d      = '0;
        pop        = 1'b0;
        underrun   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_ok) begin
                    pop       = 1'b1;
                    enc_d     = head_bit;
                    tag_d.vld = 1'b1;
                    tag_d.sof = 1'b1;
                    tcnt_d    = '0;
                    state_d   = head_last ? TAIL : DATA;
                end
            end
            DATA: begin
                tag_d.vld  = 1'b1;
                tag_d.sof  = sof_pend_q;
                sof_pend_d = 1'b0;
                if (empty) begin
                    // The zero sent on the starved cycle is the first tail bit
                    underrun  = 1'b1;
                    tag_d.err = 1'b1;
                    tcnt_d    = TW'(1);
                    state_d   = TAIL;
                end else begin
                    pop   = 1'b1;
                    enc_d = head_bit;
                    if (head_last) begin
                        tcnt_d  = '0;
                        state_d = TAIL;
                    end
                end
            end
            TAIL: begin
                tag_d.vld = 1'b1;
                if (tcnt_q == TCNT_LAST) begin
                    tag_d.eof = 1'b1;
                    tcnt_d    = '0;
                    if (start_ok) begin
                        // Back-to-back: next frame's first bit goes out next cycle
                        state_d    = DATA;
                        sof_pend_d = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    tcnt_d = tcnt_q + TW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Input side: FIFO pointers, buffered-frame count and discard mode
    always_comb begin
        // A bit accepted on the underrun cycle already belongs to the dropped frame
        drop_eff = drop_q | underrun;
        push     = accept & ~drop_eff;
        drop_d   = drop_eff & ~(accept & bus.s_last);
        wr_ptr_d = push ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;
        fr_cnt_d = fr_cnt_q;
        unique case ({push & bus.s_last, pop & head_last})
            2'b10:   fr_cnt_d = fr_cnt_q + (AW+1)'(1);
            2'b01:   fr_cnt_d = fr_cnt_q - (AW+1)'(1);
            default: fr_cnt_d = fr_cnt_q;
        endcase
    end

    // FIFO storage write (contents need no reset; pointers define validity)
    always_ff @(negedge clk) begin
        if (push) begin
            mem[wr_ptr_q[AW-1:0]] <= {bus.s_last, bus.s_data};
        end
    end

    // State, FIFO control and encoder-input registers
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            tcnt_q     <= '0;
            sof_pend_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fr_cnt_q   <= '0;
            drop_q     <= 1'b0;
            enc_q      <= 1'b0;
            tag_q      <= '0;
        end else begin
            state_q    <= state_d;
            tcnt_q     <= tcnt_d;
            sof_pend_q <= sof_pend_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fr_cnt_q   <= fr_cnt_d;
            drop_q     <= drop_d;
            enc_q      <= enc_d;
            tag_q      <= tag_d;
        end
    end

    // Tag delay line matching the encoder latency
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < ENC_LAT; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q[0] <= tag_q;
            for (int unsigned i = 1; i < ENC_LAT; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    // Busy while sequencing or while any tag is still in flight
    always_comb begin
        busy_c = (state_q != IDLE) | tag_q.vld;
        for (int unsigned i = 0; i < ENC_LAT; i++) begin
            busy_c = busy_c | pipe_q[i].vld;
        end
    end

    assign bus.s_ready      = ~full;
    assign bus.enc_data_in  = enc_q;
    assign bus.m_valid      = pipe_q[ENC_LAT-1].vld;
    assign bus.m_sof        = pipe_q[ENC_LAT-1].sof;
    assign bus.m_eof        = pipe_q[ENC_LAT-1].eof;
    assign bus.err_underrun = pipe_q[ENC_LAT-1].err;
    assign bus.m_code       = pipe_q[ENC_LAT-1].vld ? bus.enc_code_in : 2'b00;
    assign bus.busy         = busy_c;

endmodule

// File: tb/tb_conv_frame_ctrl.sv
// Bench for conv_frame_ctrl: external encoder model plus a frame-level
// scoreboard that encodes each sent frame (data + zero tail) from zero state.
module tb_conv_frame_ctrl;

    localparam int DEPTH = 64;
    localparam int TAIL  = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    conv_frame_ctrl_if bus();

    conv_frame_ctrl #(.DEPTH(DEPTH), .TAIL_LEN(TAIL), .ENC_LAT(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Rate-1/2 K=5 code: win[0] is the newest bit, result is {g1 parity, g0 parity}
    function automatic logic [1:0] enc_pair(input logic [4:0] win);
        return {^(win & 5'b10011), ^(win & 5'b11101)};
    endfunction

    // External encoder: samples enc_data_in, code appears three falling edges later
    logic [3:0] enc_sh;
    logic [1:0] enc_c1, enc_c2, enc_out;
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enc_sh <= '0; enc_c1 <= '0; enc_c2 <= '0; enc_out <= '0;
        end else begin
            enc_sh  <= {enc_sh[2:0], bus.enc_data_in};
            enc_c1  <= enc_pair({enc_sh, bus.enc_data_in});
            enc_c2  <= enc_c1;
            enc_out <= enc_c2;
        end
    end
    assign bus.enc_code_in = enc_out;

    // Scoreboard state
    logic       fb [512];
    logic       exp_bits [$];
    int         exp_len [$];
    logic [1:0] got_q [$];
    logic [1:0] last_got [$];
    bit         mon_en = 0;
    bit         in_frame = 0;
    int         errpos = -1, last_errpos = -1;
    int         n_under = 0, frames_done = 0;
    int         cyc = 0, eof_cyc = 0, sof_gap = 0;
    int         stall_busy, first_stall_idx, first_stall_busy;
    bit         seen_stall;

    task automatic push_exp(input int start, input int n);
        for (int i = 0; i < n; i++) exp_bits.push_back(fb[start+i]);
        exp_len.push_back(n);
    endtask

    task automatic finish_frame();
        int n, k;
        logic bits [$];
        logic [4:0] sr;
        chk("frame_expected", int'(exp_len.size() != 0), 1);
        if (exp_len.size() != 0) begin
            n = exp_len.pop_front();
            for (int i = 0; i < n; i++) bits.push_back(exp_bits.pop_front());
            k = (errpos >= 0) ? errpos : n;
            chk("pair_count", got_q.size(), k + TAIL);
            sr = '0;
            for (int t = 0; t < k + TAIL; t++) begin
                sr = {sr[3:0], (t < k) ? bits[t] : 1'b0};
                if (t < got_q.size())
                    chk($sformatf("pair%0d", t), int'(got_q[t]), int'(enc_pair(sr)));
            end
        end
        last_got = got_q;
        last_errpos = errpos;
        frames_done++;
        in_frame = 0;
        eof_cyc = cyc;
    endtask

    // Output monitor, sampled on the rising edge (mid-cycle)
    always @(posedge clk) begin
        cyc++;
        if (mon_en) begin
            if (bus.err_underrun) n_under++;
            if (bus.m_valid) begin
                if (bus.m_sof) begin
                    chk("sof_inside_frame", int'(in_frame), 0);
                    got_q = {};
                    errpos = -1;
                    in_frame = 1;
                    sof_gap = cyc - eof_cyc;
                end else begin
                    chk("pair_without_sof", int'(in_frame), 1);
                end
                if (in_frame) begin
                    got_q.push_back(bus.m_code);
                    if (bus.err_underrun) errpos = got_q.size() - 1;
                    if (bus.m_eof) finish_frame();
                end
            end else begin
                if (in_frame) chk("gap_in_frame", int'(bus.m_valid), 1);
                chk("code_idle", int'(bus.m_code), 0);
                chk("flags_idle", int'({bus.m_sof, bus.m_eof, bus.err_underrun}), 0);
            end
        end
    end

    task automatic send_bits(input int start, input int n, input bit with_last, input int gap_pct);
        int i = start;
        int c = 0;
        while (i < start + n && c < 4000) begin
            @(posedge clk);
            c++;
            if (gap_pct != 0 && int'($urandom_range(99)) < gap_pct) begin
                bus.s_valid = 1'b0;
            end else begin
                bus.s_valid = 1'b1;
                bus.s_data  = fb[i];
                bus.s_last  = with_last && (i == start + n - 1);
                if (bus.s_ready) begin
                    i++;
                end else begin
                    if (!seen_stall) begin
                        seen_stall = 1;
                        first_stall_idx = i;
                        first_stall_busy = int'(bus.busy);
                    end
                    if (bus.busy) stall_busy++;
                end
            end
        end
        @(negedge clk);
        #1;
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
        chk("send_done", i, start + n);
    endtask

    task automatic wait_drain(input int bound);
        int c = 0;
        @(posedge clk);
        #1;
        while ((exp_len.size() != 0 || bus.busy) && c < bound) begin
            @(posedge clk);
            #1;
            c++;
        end
        chk("drain", int'(exp_len.size() == 0 && !bus.busy), 1);
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_s_ready"}, int'(bus.s_ready), 1);
        chk({tag, "_m_valid"}, int'(bus.m_valid), 0);
        chk({tag, "_m_code"}, int'(bus.m_code), 0);
        chk({tag, "_flags"}, int'({bus.m_sof, bus.m_eof, bus.err_underrun}), 0);
        chk({tag, "_busy"}, int'(bus.busy), 0);
        chk({tag, "_enc"}, int'(bus.enc_data_in), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int t1_exp [5] = '{3, 2, 1, 1, 3};
        int f0, n0, n;
        bus.s_valid = 1'b0;
        bus.s_data  = 1'b0;
        bus.s_last  = 1'b0;
        repeat (3) @(posedge clk);
        check_idle_outputs("reset");
        @(posedge clk);
        rst_n = 1'b1;
        mon_en = 1;
        repeat (2) @(posedge clk);

        // Single-bit frame: impulse response plus sof/eof spacing
        fb[0] = 1'b1;
        push_exp(0, 1);
        send_bits(0, 1, 1, 0);
        wait_drain(200);
        chk("t1_pairs", last_got.size(), 5);
        for (int i = 0; i < 5 && i < last_got.size(); i++)
            chk($sformatf("t1_code%0d", i), int'(last_got[i]), t1_exp[i]);

        // Two frames back-to-back: eof and next sof on adjacent cycles
        fb[0] = 1; fb[1] = 0; fb[2] = 1; fb[3] = 1; fb[4] = 0;
        f0 = frames_done;
        push_exp(0, 4);
        push_exp(4, 1);
        send_bits(0, 4, 1, 0);
        send_bits(4, 1, 1, 0);
        wait_drain(200);
        chk("b2b_frames", frames_done - f0, 2);
        chk("b2b_sof_gap", sof_gap, 1);

        // 200-bit gap-free frame: starts on FIFO full, no later backpressure
        for (int i = 0; i < 200; i++) fb[i] = 1'($urandom);
        seen_stall = 0; stall_busy = 0; first_stall_idx = -1; first_stall_busy = -1;
        push_exp(0, 200);
        send_bits(0, 200, 1, 0);
        wait_drain(600);
        chk("long_start_idx", first_stall_idx, DEPTH);
        chk("long_start_idle", first_stall_busy, 0);
        chk("long_ready_after_start", stall_busy, 0);
        chk("long_no_underrun", last_errpos, -1);
        chk("long_pairs", last_got.size(), 204);

        // Underrun: input stalls after bit 66, remainder of the frame is dropped
        for (int i = 0; i < 70; i++) fb[i] = 1'($urandom);
        for (int i = 100; i < 110; i++) fb[i] = 1'($urandom);
        push_exp(0, 70);
        n0 = n_under;
        send_bits(0, 66, 0, 0);
        for (int c = 0; c < 300 && n_under == n0; c++) @(posedge clk);
        chk("underrun_pulse", n_under - n0, 1);
        wait_drain(200);
        chk("underrun_pos", last_errpos, 66);
        chk("underrun_pairs", last_got.size(), 70);
        send_bits(66, 4, 1, 0);
        push_exp(100, 10);
        send_bits(100, 10, 1, 0);
        wait_drain(300);
        chk("post_underrun_clean", last_errpos, -1);
        chk("post_underrun_pairs", last_got.size(), 14);

        // Reset in the middle of the tail with unterminated bits buffered
        mon_en = 0;
        for (int i = 0; i < 20; i++) fb[i] = 1'($urandom);
        send_bits(0, 10, 1, 0);
        send_bits(10, 10, 0, 0);
        @(negedge clk);
        @(posedge clk);
        chk("busy_before_reset", int'(bus.busy), 1);
        rst_n = 1'b0;
        #1;
        check_idle_outputs("midreset");
        in_frame = 0; got_q = {}; errpos = -1;
        exp_len.delete();
        exp_bits.delete();
        repeat (2) @(posedge clk);
        rst_n = 1'b1;
        mon_en = 1;
        repeat (3) @(posedge clk);
        check_idle_outputs("postreset");
        fb[0] = 1'b1;
        push_exp(0, 1);
        send_bits(0, 1, 1, 0);
        wait_drain(200);
        chk("postreset_pairs", last_got.size(), 5);

        // Random frames with random input gaps
        f0 = frames_done;
        for (int f = 0; f < 12; f++) begin
            n = int'($urandom_range(1, 300));
            for (int i = 0; i < n; i++) fb[i] = 1'($urandom);
            push_exp(0, n);
            send_bits(0, n, 1, 12);
        end
        wait_drain(5000);
        chk("rand_frames", frames_done - f0, 12);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
